pbkdf2_job_arbiter: RTL and testbench

//  Shares one pbkdf2 core among NUM_REQ requesters. Round-robin picks one pending
//  job, latches its operands, issues it to the core and holds them stable. Waits
//  for the derived key, then returns it to the granted requester only.

---
 rtl/pbkdf2_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/pbkdf2_job_arbiter.sv | 131 +++++++++++++
 tb/tb_pbkdf2_job_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pbkdf2_pkg.sv
// Shared widths and FSM state type for the pbkdf2 job arbiter.
//   ITER_W / PASS_W / SALT_W / SALT_LEN_W / HASH_W : operand and result widths
//   arb_state_e : arbiter FSM states
package pbkdf2_pkg;

    localparam int ITER_W     = 32;
    localparam int PASS_W     = 512;
    localparam int SALT_W     = 512;
    localparam int SALT_LEN_W = 6;
    localparam int HASH_W     = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req_i       : request vector, one bit per requester
//   ptr_i       : highest-priority index for this pick
//   gnt_valid_o : at least one request is pending
//   gnt_id_o    : first requesting index at or above ptr_i, wrapping
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic               gnt_valid_o,
    output logic [ID_W-1:0]    gnt_id_o
);

    int idx;

    // Walk offsets from farthest to nearest so the nearest match to ptr_i
    // is the last assignment and therefore wins.
    always_comb begin
        gnt_valid_o = 1'b0;
        gnt_id_o    = '0;
        idx         = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr_i) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req_i[idx]) begin
                gnt_valid_o = 1'b1;
                gnt_id_o    = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/pbkdf2_job_arbiter.sv
// Shares one pbkdf2 core among NUM_REQ requesters. A round-robin pick in IDLE
// accepts one job, latches its operands, presents them to the core until it
// accepts, waits for the derived key and returns it to the granted port only.
// Jobs with iters==0 never reach the core; they are answered with err=1.
//   clk_i / rst_ni      : clock, async active-low reset
//   req_*               : per-requester job ports (valid/ready + packed operands)
//   resp_*              : per-requester result ports (valid/ready), shared hash/err
//   core_in_* / core_*_o: operand handshake to the core
//   core_out_* / core_hash_i : result handshake from the core
//   busy_o, grant_id_o  : status of the job in service
module pbkdf2_job_arbiter
    import pbkdf2_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ*ITER_W-1:0]     req_iters_i,
    input  logic [NUM_REQ*PASS_W-1:0]     req_pass_i,
    input  logic [NUM_REQ*SALT_W-1:0]     req_salt_i,
    input  logic [NUM_REQ*SALT_LEN_W-1:0] req_salt_len_i,
    output logic [NUM_REQ-1:0]            resp_valid_o,
    input  logic [NUM_REQ-1:0]            resp_ready_i,
    output logic [HASH_W-1:0]             resp_hash_o,
    output logic                          resp_err_o,
    output logic                          core_in_valid_o,
    input  logic                          core_in_ready_i,
    output logic [ITER_W-1:0]             core_iters_o,
    output logic [PASS_W-1:0]             core_pass_o,
    output logic [SALT_W-1:0]             core_salt_o,
    output logic [SALT_LEN_W-1:0]         core_salt_len_o,
    input  logic                          core_out_valid_i,
    output logic                          core_out_ready_o,
    input  logic [HASH_W-1:0]             core_hash_i,
    output logic                          busy_o,
    output logic [ID_W-1:0]               grant_id_o
);

    arb_state_e              state_q;
    logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]         grant_id_q;
    logic [ITER_W-1:0]       iters_q;
    logic [PASS_W-1:0]       pass_q;
    logic [SALT_W-1:0]       salt_q;
    logic [SALT_LEN_W-1:0]   salt_len_q;
    logic [HASH_W-1:0]       hash_q;
    logic                    err_q;

    logic                    gnt_valid;
    logic [ID_W-1:0]         gnt_id;
    logic                    accept;
    logic [ITER_W-1:0]       win_iters;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req_i       (req_valid_i),
        .ptr_i       (rr_ptr_q),
        .gnt_valid_o (gnt_valid),
        .gnt_id_o    (gnt_id)
    );

    // rst_ni gates the combinational ready so nothing handshakes while in reset.
    assign accept    = rst_ni && (state_q == IDLE) && gnt_valid;
    assign win_iters = req_iters_i[ITER_W*gnt_id +: ITER_W];
    assign rr_ptr_d  = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            iters_q    <= '0;
            pass_q     <= '0;
            salt_q     <= '0;
            salt_len_q <= '0;
            hash_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        grant_id_q <= gnt_id;
                        rr_ptr_q   <= rr_ptr_d;
                        iters_q    <= win_iters;
                        pass_q     <= req_pass_i[PASS_W*gnt_id +: PASS_W];
                        salt_q     <= req_salt_i[SALT_W*gnt_id +: SALT_W];
                        salt_len_q <= req_salt_len_i[SALT_LEN_W*gnt_id +: SALT_LEN_W];
                        // The core never terminates on zero iterations: answer directly.
                        if (win_iters == '0) begin
                            hash_q  <= '0;
                            err_q   <= 1'b1;
                            state_q <= RESP;
                        end else begin
                            err_q   <= 1'b0;
                            state_q <= ISSUE;
                        end
                    end
                end
                ISSUE: if (core_in_ready_i) state_q <= WAIT;
                WAIT: begin
                    if (core_out_valid_i) begin
                        hash_q  <= core_hash_i;
                        err_q   <= 1'b0;
                        state_q <= RESP;
                    end
                end
                RESP: if (resp_ready_i[grant_id_q]) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready_o      = accept ? (NUM_REQ'(1) << gnt_id) : '0;
    assign resp_valid_o     = (state_q == RESP) ? (NUM_REQ'(1) << grant_id_q) : '0;
    assign resp_hash_o      = hash_q;
    assign resp_err_o       = err_q;
    assign core_in_valid_o  = (state_q == ISSUE);
    assign core_out_ready_o = (state_q == WAIT);
    assign core_iters_o     = iters_q;
    assign core_pass_o      = pass_q;
    assign core_salt_o      = salt_q;
    assign core_salt_len_o  = salt_len_q;
    assign busy_o           = (state_q != IDLE);
    assign grant_id_o       = grant_id_q;

endmodule

// File: tb/tb_pbkdf2_job_arbiter.sv
module tb_pbkdf2_job_arbiter;

    localparam int N = 4;

    typedef struct {
        int           port;
        logic [255:0] hash;
        logic         err;
    } exp_t;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready_o;
    logic [N*32-1:0]  req_iters;
    logic [N*512-1:0] req_pass;
    logic [N*512-1:0] req_salt;
    logic [N*6-1:0]   req_salt_len;
    logic [N-1:0]     resp_valid_o;
    logic [N-1:0]     resp_rdy;
    logic [255:0]     resp_hash_o;
    logic             resp_err_o;
    logic             core_in_valid_o;
    logic             m_in_rdy;
    logic [31:0]      core_iters_o;
    logic [511:0]     core_pass_o;
    logic [511:0]     core_salt_o;
    logic [5:0]       core_salt_len_o;
    logic             core_out_valid_i;
    logic             core_out_ready_o;
    logic [255:0]     core_hash_i;
    logic             busy_o;
    logic [1:0]       grant_id_o;

    // behavioural core model
    logic             m_pend, m_out_v, spur;
    logic [31:0]      m_it;
    int               m_cnt, lat;
    logic [255:0]     m_hash;

    int   n_tests = 0, n_fail = 0;
    exp_t exp_q[$];
    int   grants[$];
    logic saw_civ;

    always #5 clk_i = ~clk_i;

    pbkdf2_job_arbiter #(.NUM_REQ(N)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid), .req_ready_o(req_ready_o),
        .req_iters_i(req_iters), .req_pass_i(req_pass), .req_salt_i(req_salt),
        .req_salt_len_i(req_salt_len),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_rdy),
        .resp_hash_o(resp_hash_o), .resp_err_o(resp_err_o),
        .core_in_valid_o(core_in_valid_o), .core_in_ready_i(m_in_rdy),
        .core_iters_o(core_iters_o), .core_pass_o(core_pass_o),
        .core_salt_o(core_salt_o), .core_salt_len_o(core_salt_len_o),
        .core_out_valid_i(core_out_valid_i), .core_out_ready_o(core_out_ready_o),
        .core_hash_i(core_hash_i), .busy_o(busy_o), .grant_id_o(grant_id_o)
    );

    function automatic logic [255:0] hash_for(logic [31:0] it);
        return (it == 32'd1) ? {32{8'hA5}} : {8{it}};
    endfunction

    function automatic logic [511:0] pass_for(logic [31:0] it);
        return {16{it ^ 32'hC0DE_0000}};
    endfunction

    function automatic logic [511:0] salt_for(logic [31:0] it);
        return {16{it ^ 32'h5A17_0000}};
    endfunction

    task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Core model: after accepting operands, waits lat cycles then offers its hash.
    assign core_out_valid_i = m_out_v | spur;
    assign core_hash_i      = spur ? {8{32'hDEAD_BEEF}} : m_hash;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_pend <= 1'b0; m_out_v <= 1'b0; m_cnt <= 0; m_it <= '0; m_hash <= '0;
        end else begin
            if (m_out_v && core_out_ready_o) begin
                m_out_v <= 1'b0;
                m_pend  <= 1'b0;
            end else if (m_pend && !m_out_v) begin
                if (m_cnt == 0) begin
                    m_out_v <= 1'b1;
                    m_hash  <= hash_for(m_it);
                end else m_cnt <= m_cnt - 1;
            end
            if (core_in_valid_o && m_in_rdy) begin
                m_pend <= 1'b1;
                m_cnt  <= lat;
                m_it   <= core_iters_o;
            end
        end
    end

    // Grant monitor: records grant order and pushes the expected response.
    always @(negedge clk_i) begin
        if (rst_ni === 1'b1 && |req_ready_o) begin
            int   id;
            exp_t e;
            id = 0;
            for (int i = 0; i < N; i++) if (req_ready_o[i]) id = i;
            chk("req_ready_onehot", 256'($onehot(req_ready_o)), 256'(1));
            chk("req_ready_only_valid", 256'(req_ready_o & ~req_valid), 256'(0));
            e.port = id;
            e.err  = (req_iters[32*id +: 32] == 32'd0);
            e.hash = e.err ? 256'd0 : hash_for(req_iters[32*id +: 32]);
            grants.push_back(id);
            exp_q.push_back(e);
        end
        if (core_in_valid_o === 1'b1) saw_civ = 1'b1;
    end

    // Response monitor: pops the scoreboard on every completed response handshake.
    always @(negedge clk_i) begin
        if (rst_ni === 1'b1 && |resp_valid_o) begin
            chk("resp_valid_onehot", 256'($onehot(resp_valid_o)), 256'(1));
            if (|(resp_valid_o & resp_rdy)) begin
                int   p;
                exp_t e;
                p = 0;
                for (int i = 0; i < N; i++) if (resp_valid_o[i]) p = i;
                if (exp_q.size() == 0) begin
                    chk("resp_unexpected", 256'(1), 256'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_port", 256'(p), 256'(e.port));
                    chk("resp_hash", resp_hash_o, e.hash);
                    chk("resp_err", 256'(resp_err_o), 256'(e.err));
                end
            end
        end
    end

    task automatic set_port(int p, logic [31:0] it, logic [5:0] sl);
        req_iters[32*p +: 32]   = it;
        req_pass[512*p +: 512]  = pass_for(it);
        req_salt[512*p +: 512]  = salt_for(it);
        req_salt_len[6*p +: 6]  = sl;
    endtask

    // Raises valid on port p and drops it right after its grant transfers.
    task automatic send(int p, logic [31:0] it, logic [5:0] sl);
        int g0;
        bit ok;
        g0 = grants.size();
        ok = 0;
        set_port(p, it, sl);
        req_valid[p] = 1'b1;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(posedge clk_i); #1;
            if (grants.size() > g0 && grants[grants.size()-1] == p) ok = 1;
        end
        req_valid[p] = 1'b0;
        chk("send_grant_timeout", 256'(ok), 256'(1));
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int c = 0; c < 300 && !ok; c++) begin
            @(posedge clk_i); #1;
            if (!busy_o && exp_q.size() == 0 && req_valid == '0) ok = 1;
        end
        chk("wait_idle_timeout", 256'(ok), 256'(1));
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
    endtask

    initial begin
        rst_ni = 1'b0; req_valid = '1; req_iters = '0; req_pass = '0; req_salt = '0;
        req_salt_len = '0; resp_rdy = '1; m_in_rdy = 1'b1; spur = 1'b0; lat = 2;
        saw_civ = 1'b0;
        for (int i = 0; i < N; i++) set_port(i, 32'd3, 6'd1);
        repeat (3) @(posedge clk_i);
        #1;
        // reset state, even with all requesters valid
        chk("rst_req_ready", 256'(req_ready_o), 256'(0));
        chk("rst_busy", 256'(busy_o), 256'(0));
        chk("rst_resp_valid", 256'(resp_valid_o), 256'(0));
        chk("rst_core_in_valid", 256'(core_in_valid_o), 256'(0));
        chk("rst_core_out_ready", 256'(core_out_ready_o), 256'(0));
        chk("rst_err", 256'(resp_err_o), 256'(0));
        chk("rst_hash", resp_hash_o, 256'(0));
        chk("rst_grant_id", 256'(grant_id_o), 256'(0));
        chk("rst_core_iters", 256'(core_iters_o), 256'(0));
        req_valid = '0;
        rst_ni = 1'b1;

        // 1: single job on port 2
        send(2, 32'd1, 6'd4);
        chk("t1_core_in_valid", 256'(core_in_valid_o), 256'(1));
        chk("t1_core_iters", 256'(core_iters_o), 256'(1));
        chk("t1_core_salt_len", 256'(core_salt_len_o), 256'(4));
        chk("t1_core_pass", 256'(core_pass_o[255:0]), pass_for(32'd1)[255:0]);
        chk("t1_grant_id", 256'(grant_id_o), 256'(2));
        wait_idle();

        // 2: all four held valid from reset -> 0,1,2,3,0
        do_reset();
        grants.delete();
        for (int i = 0; i < N; i++) set_port(i, 32'(16 + i), 6'(i));
        req_valid = '1;
        for (int c = 0; c < 400 && grants.size() < 5; c++) begin
            @(posedge clk_i); #1;
        end
        req_valid = '0;
        chk("t2_grant_count", 256'(grants.size()), 256'(5));
        if (grants.size() >= 5) begin
            chk("t2_g0", 256'(grants[0]), 256'(0));
            chk("t2_g1", 256'(grants[1]), 256'(1));
            chk("t2_g2", 256'(grants[2]), 256'(2));
            chk("t2_g3", 256'(grants[3]), 256'(3));
            chk("t2_g4", 256'(grants[4]), 256'(0));
        end
        wait_idle();

        // 3: iters==0 bypasses the core
        saw_civ = 1'b0;
        send(1, 32'd0, 6'd2);
        chk("t3_resp_valid", 256'(resp_valid_o), 256'(4'b0010));
        chk("t3_err", 256'(resp_err_o), 256'(1));
        chk("t3_hash", resp_hash_o, 256'(0));
        wait_idle();
        chk("t3_no_core_valid", 256'(saw_civ), 256'(0));

        // 4: stalled core input then stalled response; competitor on port 0 waits
        m_in_rdy = 1'b0;
        resp_rdy = '0;
        send(3, 32'd5, 6'd9);
        set_port(0, 32'd7, 6'd3);
        req_valid[0] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            chk("t4_civ_held", 256'(core_in_valid_o), 256'(1));
            chk("t4_iters_stable", 256'(core_iters_o), 256'(5));
            chk("t4_salt_stable", core_salt_o[255:0], salt_for(32'd5)[255:0]);
            chk("t4_no_grant", 256'(req_ready_o), 256'(0));
            @(posedge clk_i); #1;
        end
        m_in_rdy = 1'b1;
        for (int c = 0; c < 50 && resp_valid_o == '0; c++) begin
            @(posedge clk_i); #1;
        end
        for (int c = 0; c < 5; c++) begin
            chk("t4_resp_held", 256'(resp_valid_o), 256'(4'b1000));
            chk("t4_hash_stable", resp_hash_o, hash_for(32'd5));
            chk("t4_no_grant2", 256'(req_ready_o), 256'(0));
            @(posedge clk_i); #1;
        end
        resp_rdy = '1;
        for (int c = 0; c < 50 && grants[grants.size()-1] != 0; c++) begin
            @(posedge clk_i); #1;
        end
        req_valid[0] = 1'b0;
        chk("t4_competitor_granted", 256'(grants[grants.size()-1]), 256'(0));
        wait_idle();

        // 6: spurious core_out_valid_i in IDLE and ISSUE
        spur = 1'b1;
        @(posedge clk_i); #1;
        spur = 1'b0;
        chk("t6_idle_busy", 256'(busy_o), 256'(0));
        chk("t6_idle_resp", 256'(resp_valid_o), 256'(0));
        m_in_rdy = 1'b0;
        send(2, 32'd9, 6'd8);
        spur = 1'b1;
        @(posedge clk_i); #1;
        spur = 1'b0;
        chk("t6_issue_held", 256'(core_in_valid_o), 256'(1));
        chk("t6_issue_resp", 256'(resp_valid_o), 256'(0));
        m_in_rdy = 1'b1;
        wait_idle();

        // 5: reset in WAIT, then arbitration restarts from rr_ptr=0
        lat = 20;
        send(2, 32'd3, 6'd5);
        for (int c = 0; c < 20 && !core_out_ready_o; c++) begin
            @(posedge clk_i); #1;
        end
        chk("t5_in_wait", 256'(core_out_ready_o), 256'(1));
        set_port(1, 32'd11, 6'd1);
        set_port(3, 32'd13, 6'd1);
        req_valid = 4'b1010;
        #2 rst_ni = 1'b0;
        #1;
        chk("t5_busy", 256'(busy_o), 256'(0));
        chk("t5_req_ready", 256'(req_ready_o), 256'(0));
        chk("t5_core_out_ready", 256'(core_out_ready_o), 256'(0));
        chk("t5_core_iters", 256'(core_iters_o), 256'(0));
        chk("t5_grant_id", 256'(grant_id_o), 256'(0));
        exp_q.delete();
        lat = 1;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        begin
            int g0;
            g0 = grants.size();
            for (int c = 0; c < 50 && grants.size() == g0; c++) begin
                @(posedge clk_i); #1;
            end
            req_valid[1] = 1'b0;
            chk("t5_first_grant", 256'(grants[grants.size()-1]), 256'(1));
            for (int c = 0; c < 100 && grants[grants.size()-1] != 3; c++) begin
                @(posedge clk_i); #1;
            end
            req_valid[3] = 1'b0;
            chk("t5_second_grant", 256'(grants[grants.size()-1]), 256'(3));
        end
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
